div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider that answers the execute stage's divide request interface. It serves DIV and DIVU.
- It accepts operands on a start request and iterates one quotient bit per clock. It then returns {remainder, quotient} for the HI/LO write, holding ready until the requester drops start.
- It supports abort via annul and returns a zero result on divide-by-zero.

Parameters:
DATA_W, 32, operand width; result is 2*DATA_W; iteration count equals DATA_W

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset
signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start
opdata1_i  in  DATA_W  dividend; sampled with start
opdata2_i  in  DATA_W  divisor; sampled with start
start_i  in  1  request; 1 = DivStart, 0 = DivStop
annul_i  in  1  abort in-flight division
result_o  out  2*DATA_W  {remainder (HI), quotient (LO)}, registered
ready_o  out  1  1 = DivResultReady, 0 = DivResultNotReady, registered

Behaviour:
- Reset is rst, synchronous, active-high.
  - On reset: state=FREE, cnt=0, internal dividend/divisor regs=0, result_o=0, ready_o=0.
  - Reset mid-operation discards all work. No ready pulse follows.
- The FSM has four states: FREE, BYZERO, ON, END.
- FREE:
  - ready_o=0, result_o=0.
  - If start_i=1 and annul_i=0:
    - If opdata2_i==0, go to BYZERO.
    - Otherwise latch the operands and go to ON with cnt=0.
  - If start_i=1 and annul_i=1, stay in FREE.
- Operand capture on leaving FREE for ON:
  - Signed mode: a negative operand is replaced by its two's complement magnitude (~x+1). 0x80000000 stays 0x80000000 and is treated as unsigned magnitude.
  - Unsigned mode: operands are used as-is.
  - The original signs of op1 and op2 are latched for the final fix-up.
  - Working register: dividend (2*DATA_W+1 bits) = {DATA_W'0, |op1|, 1'b0}. divisor = |op2|.
- ON:
  - annul_i=1: go to FREE; ready_o and result_o stay 0. Takes priority over iteration.
  - cnt < DATA_W, one iteration per clock:
    - Compute t = {1'b0, dividend[2W-1:W]} - {1'b0, divisor}.
    - If t[W]=1 (negative): dividend <= {dividend[2W-1:0], 1'b0}.
    - Otherwise: dividend <= {t[W-1:0], dividend[W-1:0], 1'b1}.
    - cnt <= cnt+1.
  - cnt == DATA_W, finalize:
    - Quotient q = dividend[W-1:0]. Remainder r = dividend[2W:W+1].
    - Signed mode: q is negated if sign(op1) xor sign(op2); r is negated if sign(op1).
    - result_o <= {r, q}, ready_o <= 1, go to END, cnt <= 0.
- BYZERO: next clock, result_o <= 0, ready_o <= 1, go to END.
- END:
  - Hold result_o and ready_o while start_i=1.
  - When start_i=0: go to FREE; result_o <= 0, ready_o <= 0.
  - annul_i is ignored in END.
- Start and operand rules:
  - Changes on start_i and operands while in ON or BYZERO are ignored. Operands are used only as latched.
  - A new request is accepted only from FREE. Back-to-back divides need at least one clock with start_i=0.
- Latency, counting from the edge that samples start_i=1 in FREE (edge 0):
  - Normal divide: ready_o is high after edge DATA_W+1, i.e. it is first observed high in cycle 34 for DATA_W=32.
  - Divide-by-zero: ready_o is high after edge 1 (2 cycles).
- Widths: cnt has $clog2(DATA_W)+1 bits, wraps never (it is cleared at finalize). Subtraction is DATA_W+1 bits.

Test Plan:
1. Unsigned 100/7, signed_div_i=0, start held -> after 34 clocks ready_o=1, result_o=0x00000002_0000000E. Hold start 3 more clocks -> result stable. Drop start -> next clock ready_o=0, result_o=0.
2. Signed -7/2 (0xFFFFFFF9, 0x00000002) -> result_o=0xFFFFFFFF_FFFFFFFD. Signed 7/-2 -> 0x00000001_FFFFFFFD.
3. Signed 0x80000000 / 0xFFFFFFFF -> result_o=0x00000000_80000000. Unsigned 0xFFFFFFFF/1 -> 0x00000000_FFFFFFFF.
4. Divide by zero, 1234/0 -> ready_o=1 after 2 clocks, result_o=0. Second request 10/3 after dropping start -> 0x00000001_00000003 in 34 clocks.
5. Start 1000/3, assert annul_i for one clock at cycle 10 -> FSM returns to FREE, ready_o never rises. Fresh start 9/3 -> 0x00000000_00000003 in 34 clocks.
6. rst asserted at cycle 20 of a divide -> next clock all outputs 0, state FREE. Operands changed mid-ON on an unreset run -> result reflects the originally latched operands.

Source files
------------

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle radix-2 restoring divider for DIV/DIVU
// Returns {remainder, quotient}; ready holds until the requester drops start.
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  localparam logic [1:0] S_FREE   = 2'd0;
  localparam logic [1:0] S_BYZERO = 2'd1;
  localparam logic [1:0] S_ON     = 2'd2;
  localparam logic [1:0] S_END    = 2'd3;

  localparam logic [DATA_W-1:0] ONE      = 1;
  localparam logic [CNT_W-1:0]  CNT_ONE  = 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W);

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2*DATA_W:0]     dividend_q, dividend_d;
  logic [DATA_W-1:0]     divisor_q, divisor_d;
  logic                  neg_q_q, neg_q_d;
  logic                  neg_r_q, neg_r_d;
  logic [2*DATA_W-1:0]   result_q, result_d;
  logic                  ready_q, ready_d;

  logic [DATA_W-1:0]     abs1, abs2;
  logic [DATA_W:0]       sub;
  logic [DATA_W-1:0]     quo, rem;

  always_comb begin
    // 0x80000000 negates to itself and is then read as an unsigned magnitude
    abs1 = (signed_div_i && opdata1_i[DATA_W-1]) ? (~opdata1_i + ONE) : opdata1_i;
    abs2 = (signed_div_i && opdata2_i[DATA_W-1]) ? (~opdata2_i + ONE) : opdata2_i;
    sub  = {1'b0, dividend_q[2*DATA_W-1:DATA_W]} - {1'b0, divisor_q};
    quo  = neg_q_q ? (~dividend_q[DATA_W-1:0] + ONE) : dividend_q[DATA_W-1:0];
    rem  = neg_r_q ? (~dividend_q[2*DATA_W:DATA_W+1] + ONE) : dividend_q[2*DATA_W:DATA_W+1];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    neg_q_d    = neg_q_q;
    neg_r_d    = neg_r_q;
    result_d   = result_q;
    ready_d    = ready_q;

    case (state_q)
      S_FREE: begin
        result_d = '0;
        ready_d  = 1'b0;
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = S_BYZERO;
          end else begin
            state_d    = S_ON;
            cnt_d      = '0;
            dividend_d = {{DATA_W{1'b0}}, abs1, 1'b0};
            divisor_d  = abs2;
            neg_q_d    = signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
            neg_r_d    = signed_div_i & opdata1_i[DATA_W-1];
          end
        end
      end

      S_BYZERO: begin
        result_d = '0;
        ready_d  = 1'b1;
        state_d  = S_END;
      end

      S_ON: begin
        if (annul_i) begin
          state_d  = S_FREE;
          cnt_d    = '0;
          result_d = '0;
          ready_d  = 1'b0;
        end else if (cnt_q != CNT_LAST) begin
          if (sub[DATA_W]) begin
            dividend_d = {dividend_q[2*DATA_W-1:0], 1'b0};
          end else begin
            dividend_d = {sub[DATA_W-1:0], dividend_q[DATA_W-1:0], 1'b1};
          end
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          result_d = {rem, quo};
          ready_d  = 1'b1;
          state_d  = S_END;
          cnt_d    = '0;
        end
      end

      default: begin
        if (!start_i) begin
          state_d  = S_FREE;
          result_d = '0;
          ready_d  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FREE;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      result_q   <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      neg_q_q    <= neg_q_d;
      neg_r_q    <= neg_r_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - scoreboard bench for div_unit
// Expected results are queued at issue time and popped when ready_o rises.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        signed_div_i = 1'b0;
  logic [31:0] opdata1_i = '0;
  logic [31:0] opdata2_i = '0;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic [63:0] result_o;
  logic        ready_o;

  div_unit #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    int          lat;
    int          edge0;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic ready_prev = 1'b0;
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every rising ready_o must match the oldest outstanding request
  always @(negedge clk) begin
    if (ready_o && !ready_prev) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_ready", 64'd1, 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("result", result_o, mon_e.res);
        chk("latency", 64'(cyc - mon_e.edge0), 64'(mon_e.lat));
      end
    end
    ready_prev = ready_o;
  end

  task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input int lat, input bit push);
    exp_t e;
    @(negedge clk);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    e.res   = exp;
    e.lat   = lat;
    e.edge0 = cyc + 1;
    if (push) sb_q.push_back(e);
  endtask

  task automatic wait_ready(input string name);
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (ready_o) break;
    end
    chk(name, 64'(ready_o), 64'd1);
  endtask

  task automatic drop_start(input string name);
    start_i = 1'b0;
    @(negedge clk);
    chk(name, {result_o[62:0], ready_o}, 64'd0);
  endtask

  task automatic run(input string name, input logic sgn, input logic [31:0] a,
                     input logic [31:0] b, input logic [63:0] exp, input int lat);
    issue(sgn, a, b, exp, lat, 1'b1);
    wait_ready(name);
    drop_start({name, "_drop"});
  endtask

  task automatic expect_quiet(input string name, input int n);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (ready_o) seen = 1'b1;
    end
    chk(name, 64'(seen), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_ready", 64'(ready_o), 64'd0);
    chk("reset_result", result_o, 64'd0);
    rst = 1'b0;

    // 100/7 with start held three extra clocks
    issue(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, 1'b1);
    wait_ready("u100_7_ready");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_result", result_o, 64'h00000002_0000000E);
      chk("hold_ready", 64'(ready_o), 64'd1);
    end
    drop_start("u100_7_drop");

    run("s_m7_2",     1'b1, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 33);
    run("s_7_m2",     1'b1, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33);
    run("s_min_m1",   1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33);
    run("u_max_1",    1'b0, 32'hFFFFFFFF, 32'h00000001, 64'h00000000_FFFFFFFF, 33);
    run("u_max_16",   1'b0, 32'hFFFFFFFF, 32'h00000010, 64'h0000000F_0FFFFFFF, 33);
    run("s_m100_m7",  1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 64'hFFFFFFFE_0000000E, 33);
    run("s_min_2",    1'b1, 32'h80000000, 32'h00000002, 64'h00000000_C0000000, 33);
    run("u_min_2",    1'b0, 32'h80000000, 32'h00000002, 64'h00000000_40000000, 33);

    run("byzero",     1'b0, 32'd1234, 32'd0, 64'd0, 1);
    run("u10_3",      1'b0, 32'd10, 32'd3, 64'h00000001_00000003, 33);

    // Annul at cycle 10 of a divide; no result may follow
    issue(1'b0, 32'd1000, 32'd3, 64'd0, 0, 1'b0);
    repeat (10) @(negedge clk);
    annul_i = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    expect_quiet("annul_no_ready", 40);
    run("u9_3",       1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33);

    // Reset in the middle of a divide
    issue(1'b0, 32'd1000, 32'd7, 64'd0, 0, 1'b0);
    repeat (20) @(negedge clk);
    rst     = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    chk("midrst_ready", 64'(ready_o), 64'd0);
    chk("midrst_result", result_o, 64'd0);
    rst = 1'b0;
    expect_quiet("midrst_no_ready", 40);

    // Operands change while ON; latched values must win
    issue(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, 1'b1);
    repeat (5) @(negedge clk);
    signed_div_i = 1'b1;
    opdata1_i    = 32'd50;
    opdata2_i    = 32'd5;
    wait_ready("opchg_ready");
    drop_start("opchg_drop");

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
